// File: rtl/iob_ram_sp_bist_if.sv
// RAM-side bus of the single-port RAM BIST engine.
// The master is the BIST engine and the slave is the RAM.
interface iob_ram_sp_bist_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              ram_en_o;
    logic              ram_we_o;
    logic [ADDR_W-1:0] ram_addr_o;
    logic [DATA_W-1:0] ram_d_o;
    logic [DATA_W-1:0] ram_d_i;

    modport master (
        output ram_en_o,
        output ram_we_o,
        output ram_addr_o,
        output ram_d_o,
        input  ram_d_i
    );

    modport slave (
        input  ram_en_o,
        input  ram_we_o,
        input  ram_addr_o,
        input  ram_d_o,
        output ram_d_i
    );
endinterface

// File: rtl/iob_ram_sp_bist.sv
// Single-port RAM BIST: writes an incrementing pattern to every word, reads it
// back and compares each word one cycle after the read is issued.
// Optional feature: define IOB_RAM_SP_BIST_STOP_ON_ERR_EN to abort the sweep
// at the first mismatch; by default the full sweep always completes.
module iob_ram_sp_bist #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 4,
    parameter int SEQ_INI = 32
) (
    input  logic                 clk_i,
    input  logic                 arst_n_i,
    input  logic                 start_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 pass_o,
    output logic                 fail_o,
    output logic [ADDR_W-1:0]    err_addr_o,
    iob_ram_sp_bist_if.master    ram_if
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_WRITE = 3'd1;
    localparam logic [2:0] ST_READ  = 3'd2;
    localparam logic [2:0] ST_CHECK = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam logic [ADDR_W-1:0] CNT_MAX = {ADDR_W{1'b1}};

    // Expected pattern word for a given address, wrapping at the word width.
    function automatic logic [DATA_W-1:0] seq_data(input logic [ADDR_W-1:0] addr);
        return DATA_W'(32'(addr) + 32'(SEQ_INI));
    endfunction

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              err_q;
    logic [ADDR_W-1:0] err_addr_q;
    logic              rd_vld_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic              start_acc_s;
    logic              cmp_err_s;

    // Start is only honoured when the engine is idle or has finished.
    assign start_acc_s = start_i && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    // Read data returned this cycle belongs to the read issued one cycle ago.
    assign cmp_err_s   = rd_vld_q && (ram_if.ram_d_i != seq_data(rd_addr_q));

    // Next-state and address counter logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_acc_s) begin
                    state_d = ST_WRITE;
                    cnt_d   = '0;
                end else begin
                    state_d = state_q;
                end
            end
            ST_WRITE: begin
                cnt_d = cnt_q + ADDR_W'(1);
                if (cnt_q == CNT_MAX) begin
                    state_d = ST_READ;
                end else begin
                    state_d = ST_WRITE;
                end
            end
            ST_READ: begin
                cnt_d = cnt_q + ADDR_W'(1);
                if (cnt_q == CNT_MAX) begin
                    state_d = ST_CHECK;
                end else begin
                    state_d = ST_READ;
                end
`ifdef IOB_RAM_SP_BIST_STOP_ON_ERR_EN
                if (cmp_err_s) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_d;
                end
`endif
            end
            ST_CHECK: begin
                state_d = ST_DONE;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Delayed read tag so the compare lines up with the returned data.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            rd_vld_q  <= 1'b0;
            rd_addr_q <= '0;
        end else begin
            rd_vld_q  <= (state_q == ST_READ);
            rd_addr_q <= cnt_q;
        end
    end

    // Sticky error flag; only the first mismatching address is kept.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else if (start_acc_s) begin
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else if (cmp_err_s && !err_q) begin
            err_q      <= 1'b1;
            err_addr_q <= rd_addr_q;
        end else begin
            err_q      <= err_q;
            err_addr_q <= err_addr_q;
        end
    end

    // Output decode from registered state only.
    always_comb begin
        busy_o            = 1'b0;
        done_o            = 1'b0;
        pass_o            = 1'b0;
        fail_o            = 1'b0;
        err_addr_o        = err_addr_q;
        ram_if.ram_en_o   = 1'b0;
        ram_if.ram_we_o   = 1'b0;
        ram_if.ram_addr_o = '0;
        ram_if.ram_d_o    = '0;
        case (state_q)
            ST_WRITE: begin
                busy_o            = 1'b1;
                ram_if.ram_en_o   = 1'b1;
                ram_if.ram_we_o   = 1'b1;
                ram_if.ram_addr_o = cnt_q;
                ram_if.ram_d_o    = seq_data(cnt_q);
            end
            ST_READ: begin
                busy_o            = 1'b1;
                ram_if.ram_en_o   = 1'b1;
                ram_if.ram_addr_o = cnt_q;
            end
            ST_CHECK: begin
                busy_o = 1'b1;
            end
            ST_DONE: begin
                done_o = 1'b1;
                pass_o = !err_q;
                fail_o = err_q;
            end
            default: begin
                busy_o = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_iob_ram_sp_bist.sv
// Bench for iob_ram_sp_bist: behavioural RAMs with read-fault injection,
// a vector table of full runs plus hand-written reset / start corner cases.
module tb_iob_ram_sp_bist;

`ifdef IOB_RAM_SP_BIST_STOP_ON_ERR_EN
    localparam int FAULT_EDGES = 23;
`else
    localparam int FAULT_EDGES = 33;
`endif

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       busy, done, pass, fail;
    logic [3:0] err_addr;
    logic       busy2, done2, pass2, fail2;
    logic [3:0] err_addr2;

    int tests  = 0;
    int failed = 0;

    iob_ram_sp_bist_if #(.DATA_W(8), .ADDR_W(4)) ram_if  ();
    iob_ram_sp_bist_if #(.DATA_W(8), .ADDR_W(4)) ram_if2 ();

    iob_ram_sp_bist #(.DATA_W(8), .ADDR_W(4), .SEQ_INI(32)) dut (
        .clk_i(clk), .arst_n_i(rst_n), .start_i(start),
        .busy_o(busy), .done_o(done), .pass_o(pass), .fail_o(fail),
        .err_addr_o(err_addr), .ram_if(ram_if.master)
    );

    iob_ram_sp_bist #(.DATA_W(8), .ADDR_W(4), .SEQ_INI(250)) dut2 (
        .clk_i(clk), .arst_n_i(rst_n), .start_i(start),
        .busy_o(busy2), .done_o(done2), .pass_o(pass2), .fail_o(fail2),
        .err_addr_o(err_addr2), .ram_if(ram_if2.master)
    );

    // Behavioural RAMs; dut's RAM can flip bit 0 on reads of chosen addresses.
    logic [7:0]  mem  [16];
    logic [7:0]  mem2 [16];
    logic [7:0]  rdata, rdata2;
    logic [15:0] fault_mask;

    always @(posedge clk) begin
        if (ram_if.ram_en_o) begin
            if (ram_if.ram_we_o) mem[ram_if.ram_addr_o] <= ram_if.ram_d_o;
            else rdata <= mem[ram_if.ram_addr_o] ^ {7'd0, fault_mask[ram_if.ram_addr_o]};
        end
    end
    always @(posedge clk) begin
        if (ram_if2.ram_en_o) begin
            if (ram_if2.ram_we_o) mem2[ram_if2.ram_addr_o] <= ram_if2.ram_d_o;
            else rdata2 <= mem2[ram_if2.ram_addr_o];
        end
    end
    assign ram_if.ram_d_i  = rdata;
    assign ram_if2.ram_d_i = rdata2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       f5;
        logic       f9;
        int         exp_edges;
        logic       exp_pass;
        logic [3:0] exp_err;
    } vec_t;

    vec_t vecs [4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {26'd0, busy, done, pass, fail, err_addr, ram_if.ram_en_o, ram_if.ram_we_o,
                ram_if.ram_addr_o, ram_if.ram_d_o, busy2, done2, pass2, fail2, err_addr2};
    endfunction

    // Pulse start for one edge (edge 0) and count edges until done is seen.
    task automatic run(output int edges);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("start_clears_done", {63'd0, done}, 64'd0);
        chk("start_clears_flags", {58'd0, pass, fail, err_addr}, 64'd0);
        chk("busy_after_start", {63'd0, busy}, 64'd1);
        edges = 0;
        while (!done && edges < 100) begin
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    initial begin
        int edges;
        rst_n      = 1'b0;
        start      = 1'b0;
        fault_mask = 16'd0;

        vecs[0] = '{f5: 1'b0, f9: 1'b0, exp_edges: 33,          exp_pass: 1'b1, exp_err: 4'd0};
        vecs[1] = '{f5: 1'b1, f9: 1'b0, exp_edges: FAULT_EDGES, exp_pass: 1'b0, exp_err: 4'd5};
        vecs[2] = '{f5: 1'b1, f9: 1'b1, exp_edges: FAULT_EDGES, exp_pass: 1'b0, exp_err: 4'd5};
        vecs[3] = '{f5: 1'b0, f9: 1'b0, exp_edges: 33,          exp_pass: 1'b1, exp_err: 4'd0};

        // Reset state and idling with start low.
        #12;
        chk("reset_outputs", all_outs(), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_after_release", all_outs(), 64'd0);

        for (int i = 0; i < 4; i++) begin
            fault_mask    = 16'd0;
            fault_mask[5] = vecs[i].f5;
            fault_mask[9] = vecs[i].f9;
            run(edges);
            chk($sformatf("v%0d_done_edge", i), 64'(edges), 64'(vecs[i].exp_edges));
            chk($sformatf("v%0d_pass", i), {63'd0, pass}, {63'd0, vecs[i].exp_pass});
            chk($sformatf("v%0d_fail", i), {63'd0, fail}, {63'd0, !vecs[i].exp_pass});
            chk($sformatf("v%0d_err_addr", i), {60'd0, err_addr}, {60'd0, vecs[i].exp_err});
            chk($sformatf("v%0d_ram_idle", i),
                {50'd0, busy, ram_if.ram_en_o, ram_if.ram_we_o, ram_if.ram_addr_o, ram_if.ram_d_o}, 64'd0);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_held", i), {59'd0, done, pass, fail, ram_if.ram_en_o, busy},
                {59'd0, 1'b1, vecs[i].exp_pass, !vecs[i].exp_pass, 1'b0, 1'b0});
            if (i == 0) begin
                chk("mem_addr0", {56'd0, mem[0]}, 64'd32);
                chk("mem_addr15", {56'd0, mem[15]}, 64'd47);
                chk("seq250_result", {56'd0, done2, pass2, fail2, err_addr2, 1'b0}, {56'd0, 8'b1100_0000});
                chk("seq250_addr0", {56'd0, mem2[0]}, 64'd250);
                chk("seq250_addr5", {56'd0, mem2[5]}, 64'd255);
                chk("seq250_addr6", {56'd0, mem2[6]}, 64'd0);
                chk("seq250_addr15", {56'd0, mem2[15]}, 64'd9);
            end
        end

        // Asynchronous reset in the middle of the write phase.
        fault_mask = 16'd0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        chk("midwrite_addr", {52'd0, ram_if.ram_we_o, ram_if.ram_addr_o, ram_if.ram_d_o},
            {52'd0, 1'b1, 4'd7, 8'd39});
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", all_outs(), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Start held high through the whole busy period must not restart the sweep.
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        edges = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            edges++;
        end
        chk("start_ignored_busy", {59'd0, ram_if.ram_addr_o, busy}, {59'd0, 4'd10, 1'b1});
        start = 1'b0;
        while (!done && edges < 100) begin
            @(posedge clk);
            #1;
            edges++;
        end
        chk("post_reset_done_edge", 64'(edges), 64'd33);
        chk("post_reset_pass", {58'd0, pass, fail, err_addr}, {58'd0, 2'b10, 4'd0});

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/iob_ram_sp_bist.md
IOB_RAM_SP_BIST -- requirements
Module: iob_ram_sp_bist

Interface
REQ-001 SHALL have parameter DATA_W, default 8, RAM word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 4, RAM address width in bits; the test sweeps all 2**ADDR_W words.
REQ-003 SHALL have parameter SEQ_INI, default 32, first value of the incremental write pattern.
REQ-004 SHALL have a single clock and an asynchronous, active-low reset, ports named clk_i and arst_n_i; ports follow in REQ-005..REQ-016.
REQ-005 clk_i  input  1  system clock; all state updates on its rising edge.
REQ-006 arst_n_i  input  1  asynchronous active-low reset.
REQ-007 start_i  input  1  begin test; sampled only in IDLE or DONE.
REQ-008 busy_o  output  1  high in WRITE, READ and CHECK.
REQ-009 done_o  output  1  level; high in DONE.
REQ-010 pass_o  output  1  level; high in DONE when no mismatch was detected.
REQ-011 fail_o  output  1  level; high in DONE when at least one mismatch was detected.
REQ-012 err_addr_o  output  ADDR_W  address of the first mismatch; 0 if none.
REQ-013 ram_en_o  output  1  RAM enable.
REQ-014 ram_we_o  output  1  RAM write enable.
REQ-015 ram_addr_o  output  ADDR_W  RAM address; ram_d_o  output  DATA_W  RAM write data.
REQ-016 ram_d_i  input  DATA_W  RAM read data, valid one cycle after a read address is sampled with ram_en_o=1, ram_we_o=0.

Function
REQ-017 SHALL implement FSM states IDLE, WRITE, READ, CHECK, DONE, with a registered address counter cnt.
REQ-018 IDLE/DONE: start_i=1 at a rising edge -> WRITE, cnt=0; err_addr_o, pass_o, fail_o cleared at that edge; start_i in any other state SHALL be ignored.
REQ-019 WRITE: ram_en_o=1, ram_we_o=1, ram_addr_o=cnt, ram_d_o=(cnt+SEQ_INI) mod 2**DATA_W; cnt increments each cycle; at cnt=2**ADDR_W-1 -> READ, cnt wraps to 0.
REQ-020 READ: ram_en_o=1, ram_we_o=0, ram_addr_o=cnt; cnt increments; at cnt=2**ADDR_W-1 -> CHECK.
REQ-021 Compare: a one-cycle-delayed valid flag and address SHALL compare ram_d_i against (addr+SEQ_INI) mod 2**DATA_W at the edge after each read issue, including the CHECK cycle for the last address.
REQ-022 First mismatch SHALL latch err_addr_o and an error flag; later mismatches SHALL not overwrite err_addr_o.
REQ-023 CHECK -> DONE after one cycle; done_o rises after edge 2*2**ADDR_W+1 counted from the edge that sampled start_i (edge 33 for ADDR_W=4).
REQ-024 DONE: pass_o = not error flag, fail_o = error flag; done_o, pass_o, fail_o held until next start_i or reset.
REQ-025 ram_en_o, ram_we_o SHALL be 0 in IDLE, CHECK and DONE; ram_addr_o, ram_d_o SHALL be 0 there.
REQ-026 All outputs SHALL be registered or decoded from registered state only; no combinational path from ram_d_i or start_i to any output.

Reset
REQ-027 arst_n_i=0 SHALL asynchronously force IDLE, cnt=0, error flag=0 and every output to 0, including mid-WRITE or mid-READ.
REQ-028 After reset release, the block SHALL stay in IDLE until start_i is sampled high.

Configuration
REQ-029 Macro IOB_RAM_SP_BIST_STOP_ON_ERR_EN defined: a mismatch in READ or CHECK SHALL move the FSM to DONE at the comparing edge, with fail_o=1 and ram_en_o=0 from the next cycle.
REQ-030 Macro undefined: the FSM SHALL always complete the full sweep; the result is reported only in DONE.

Verification
REQ-031 Fault-free behavioural RAM, defaults: start_i pulse -> 16 writes of data 32..47, 16 reads, done_o after edge 33, pass_o=1, fail_o=0, err_addr_o=0.
REQ-032 Fault injected on read data of addr 5 (bit 0 flipped), macro undefined -> full sweep, done_o after edge 33, fail_o=1, err_addr_o=5; second fault at addr 9 leaves err_addr_o=5.
REQ-033 Same fault, macro defined -> DONE one cycle after the addr-5 compare (edge 23), fail_o=1, err_addr_o=5, ram_en_o=0 afterward.
REQ-034 SEQ_INI=250, DATA_W=8: write data wraps 250..255, 0..9; addr 15 expects 9; pass_o=1.
REQ-035 arst_n_i pulsed low at write addr 7 -> all outputs 0 immediately; start_i held high during busy is ignored; new start_i after reset -> full pass.
REQ-036 start_i in DONE after a failing run -> pass_o/fail_o/err_addr_o cleared at that edge, fresh run on a good RAM ends with pass_o=1.
